// File: rtl/antirebotes_multicanal_if.sv
// Button front-end bus: raw pins and controls in, debounced levels,
// event strobes, packed counters and overflow flags out.
interface antirebotes_multicanal_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
);
   logic [N_CH-1:0]       btn_in;
   logic [1:0]            edge_mode;
   logic [N_CH-1:0]       clr;
   logic [N_CH-1:0]       btn_clean;
   logic [N_CH-1:0]       btn_pulse;
   logic                  any_pulse;
   logic [N_CH*CNT_W-1:0] count;
   logic [N_CH-1:0]       ovf;

   modport master (
      output btn_in, edge_mode, clr,
      input  btn_clean, btn_pulse, any_pulse, count, ovf
   );

   modport slave (
      input  btn_in, edge_mode, clr,
      output btn_clean, btn_pulse, any_pulse, count, ovf
   );
endinterface

// File: rtl/antirebotes_multicanal.sv
// N_CH-channel button front end: sync -> debounce -> edge -> event counter.
// Ports: clk, rst_n (sync, active-low), bus (slave side of the _if bundle).
module antirebotes_multicanal #(
   parameter int N_CH      = 4,
   parameter int STAGES    = 2,
   parameter int DB_CYCLES = 16,
   parameter int CNT_W     = 8,
   parameter bit SATURATE  = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   antirebotes_multicanal_if.slave bus
);

   localparam int DB_W = $clog2(DB_CYCLES);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [N_CH-1:0]  sync_q [STAGES];
   logic [DB_W-1:0]  db_cnt [N_CH];
   logic [N_CH-1:0]  clean_q;
   logic [N_CH-1:0]  clean_d;
   logic [CNT_W-1:0] cnt_q  [N_CH];
   logic [N_CH-1:0]  ovf_q;
   logic [N_CH-1:0]  btn_sync;
   logic [N_CH-1:0]  rise;
   logic [N_CH-1:0]  fall;
   logic [N_CH-1:0]  pulse;

   assign btn_sync = sync_q[STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= bus.btn_in;
         for (int s = 1; s < STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   // Any sample matching the accepted level restarts the stability count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clean_q <= '0;
         clean_d <= '0;
         for (int i = 0; i < N_CH; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         clean_d <= clean_q;
         for (int i = 0; i < N_CH; i++) begin
            if (btn_sync[i] == clean_q[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_MAX) begin
               clean_q[i] <= btn_sync[i];
               db_cnt[i]  <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign rise = clean_q & ~clean_d;
   assign fall = ~clean_q & clean_d;

   always_comb begin
      pulse = '0;
      unique case (bus.edge_mode)
         2'b00:   pulse = rise;
         2'b01:   pulse = fall;
         2'b10:   pulse = rise | fall;
         default: pulse = '0;
      endcase
   end

   // Clear wins over a coincident pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (bus.clr[i]) begin
               cnt_q[i] <= '0;
               ovf_q[i] <= 1'b0;
            end else if (pulse[i]) begin
               if (cnt_q[i] != CNT_MAX) begin
                  cnt_q[i] <= cnt_q[i] + CNT_W'(1);
               end else begin
                  ovf_q[i] <= 1'b1;
                  if (!SATURATE) begin
                     cnt_q[i] <= '0;
                  end
               end
            end
         end
      end
   end

   assign bus.btn_clean = clean_q;
   assign bus.btn_pulse = pulse;
   assign bus.any_pulse = |pulse;
   assign bus.ovf       = ovf_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_pack
      assign bus.count[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_antirebotes_multicanal.sv
// Bench for antirebotes_multicanal: wrapping and saturating instances
// share stimulus; pulses are scoreboarded against an expected-channel queue.
module tb_antirebotes_multicanal;

   logic clk;
   logic rst_n;

   antirebotes_multicanal_if #(.N_CH(4), .CNT_W(8)) ia ();
   antirebotes_multicanal_if #(.N_CH(4), .CNT_W(8)) ib ();

   antirebotes_multicanal #(
      .N_CH(4), .STAGES(2), .DB_CYCLES(16), .CNT_W(8), .SATURATE(1'b0)
   ) u_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ia.slave)
   );

   antirebotes_multicanal #(
      .N_CH(4), .STAGES(2), .DB_CYCLES(16), .CNT_W(8), .SATURATE(1'b1)
   ) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ib.slave)
   );

   always_comb begin
      ib.btn_in    = ia.btn_in;
      ib.edge_mode = ia.edge_mode;
      ib.clr       = ia.clr;
   end

   initial begin
      clk = 1'b0;
      forever #50 clk = ~clk;
   end

   int n_chk = 0;
   int n_err = 0;
   int ap_cnt = 0;
   int pq[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt_a(input int ch);
      return 32'(ia.count[ch*8 +: 8]);
   endfunction

   function automatic logic [31:0] cnt_b(input int ch);
      return 32'(ib.count[ch*8 +: 8]);
   endfunction

   // Every observed strobe must match the next expected channel.
   always @(negedge clk) begin
      if (rst_n) begin
         if ((ia.btn_pulse != 0) || ia.any_pulse) begin
            chk("any_pulse", 32'(ia.any_pulse), 32'(|ia.btn_pulse));
         end
         if (ia.any_pulse) ap_cnt++;
         for (int c = 0; c < 4; c++) begin
            if (ia.btn_pulse[c]) begin
               if (pq.size() == 0) begin
                  chk("pulse_extra", 32'(c), 32'hFFFF);
               end else begin
                  chk("pulse_ch", 32'(c), 32'(pq.pop_front()));
               end
            end
         end
      end
   end

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int ch, input int hi);
      ia.btn_in[ch] = 1'b1;
      settle(hi);
      ia.btn_in[ch] = 1'b0;
   endtask

   task automatic wait_clean(input int ch, output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (ia.btn_clean[ch]) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      #(60000 * 100);
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int found;
      int ap0;

      rst_n        = 1'b0;
      ia.btn_in    = '0;
      ia.edge_mode = 2'b00;
      ia.clr       = '0;
      settle(3);
      chk("rst_clean", 32'(ia.btn_clean), 0);
      chk("rst_count", ia.count, 0);
      chk("rst_ovf", 32'(ia.ovf), 0);
      rst_n = 1'b1;
      settle(2);

      // 1: bouncing input then stable high
      for (int i = 0; i < 10; i++) begin
         ia.btn_in[0] = (i % 2 == 0);
         settle(3);
      end
      pq.push_back(0);
      ia.btn_in[0] = 1'b1;
      wait_clean(0, lat);
      chk("t1_latency", 32'(lat), 18);
      settle(2);
      chk("t1_count", cnt_a(0), 1);
      ia.btn_in[0] = 1'b0;
      settle(25);
      chk("t1_clean_low", 32'(ia.btn_clean[0]), 0);
      chk("t1_no_fall", cnt_a(0), 1);

      // 2: 15-cycle glitch rejected, 16-cycle press accepted
      press(1, 15);
      settle(30);
      chk("t2_short_clean", 32'(ia.btn_clean[1]), 0);
      chk("t2_short_cnt", cnt_a(1), 0);
      pq.push_back(1);
      press(1, 16);
      settle(2);
      chk("t2_long_clean", 32'(ia.btn_clean[1]), 1);
      settle(40);
      chk("t2_long_cnt", cnt_a(1), 1);

      // 3: both-edge mode, then disabled mode
      ia.edge_mode = 2'b10;
      pq.push_back(2);
      pq.push_back(2);
      press(2, 20);
      settle(40);
      chk("t3_both", cnt_a(2), 2);
      ia.edge_mode = 2'b11;
      press(2, 20);
      settle(40);
      chk("t3_off", cnt_a(2), 2);
      ia.edge_mode = 2'b00;
      settle(2);

      // 5: clear coincident with a pulse
      pq.push_back(0);
      ia.btn_in[0] = 1'b1;
      found = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (ia.btn_pulse[0]) begin
            found = 1;
            break;
         end
      end
      chk("t5_pulse_seen", 32'(found), 1);
      ia.clr[0] = 1'b1;
      @(posedge clk);
      #1;
      ia.clr[0] = 1'b0;
      chk("t5_cnt", cnt_a(0), 0);
      chk("t5_ovf", 32'(ia.ovf[0]), 0);
      settle(1);
      chk("t5_cnt_hold", cnt_a(0), 0);
      ia.btn_in[0] = 1'b0;
      settle(40);

      // 4: 256 presses, wrap vs saturate
      for (int k = 0; k < 256; k++) begin
         pq.push_back(3);
         press(3, 20);
         settle(20);
         if (k == 254) begin
            chk("t4_w255", cnt_a(3), 255);
            chk("t4_w255_ovf", 32'(ia.ovf[3]), 0);
            chk("t4_s255", cnt_b(3), 255);
         end
      end
      chk("t4_wrap_cnt", cnt_a(3), 0);
      chk("t4_wrap_ovf", 32'(ia.ovf[3]), 1);
      chk("t4_sat_cnt", cnt_b(3), 255);
      chk("t4_sat_ovf", 32'(ib.ovf[3]), 1);

      // 6: count to 5 with a held button, reset, re-detect
      for (int k = 0; k < 4; k++) begin
         pq.push_back(0);
         press(0, 20);
         settle(20);
      end
      pq.push_back(0);
      ia.btn_in[0] = 1'b1;
      settle(25);
      chk("t6_pre_cnt", cnt_a(0), 5);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("t6_rst_clean", 32'(ia.btn_clean), 0);
      chk("t6_rst_pulse", 32'(ia.btn_pulse), 0);
      chk("t6_rst_cnt", ia.count, 0);
      chk("t6_rst_ovf", 32'(ia.ovf), 0);
      chk("t6_rst_sat", ib.count, 0);
      pq.push_back(0);
      wait_clean(0, lat);
      chk("t6_latency", 32'(lat), 18);
      settle(2);
      chk("t6_cnt", cnt_a(0), 1);

      ap0 = ap_cnt;
      pq.push_back(1);
      pq.push_back(2);
      ia.btn_in[1] = 1'b1;
      ia.btn_in[2] = 1'b1;
      settle(20);
      ia.btn_in[1] = 1'b0;
      ia.btn_in[2] = 1'b0;
      settle(25);
      chk("t6_any_once", 32'(ap_cnt - ap0), 1);
      chk("t6_cnt1", cnt_a(1), 1);
      chk("t6_cnt2", cnt_a(2), 1);

      ia.btn_in[0] = 1'b0;
      settle(25);
      chk("pq_left", 32'(pq.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
